// File: rtl/dc_volt_monitor.sv
// dc_volt_monitor: calibrates multiplexed DC-link ADC samples and raises debounced per-channel OV/UV flags.
module dc_volt_monitor #(
    parameter int W     = 12,
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int DEB_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [CHW-1:0]   data_ch,
    input  logic [W-1:0]     sample_data,
    input  logic [10:0]      cal_gain,
    input  logic [W-1:0]     cal_offset,
    input  logic [W-1:0]     ov_set,
    input  logic [W-1:0]     ov_clr,
    input  logic [W-1:0]     uv_set,
    input  logic [W-1:0]     uv_clr,
    input  logic             fault_clr,
    output logic [W-1:0]     volt_out,
    output logic [CHW-1:0]   volt_ch,
    output logic             volt_valid,
    output logic [NCH-1:0]   ov,
    output logic [NCH-1:0]   uv,
    output logic             ov_latch,
    output logic             uv_latch
);
    localparam logic [3:0] DEB = 4'(DEB_N);

    logic                s1_valid;
    logic [CHW-1:0]      s1_ch;
    logic [W:0]          s1_prod;
    logic signed [W+1:0] sum;
    logic [W-1:0]        sat;
    logic                ovc;
    logic                uvc;
    logic [3:0]          ov_cnt [NCH];
    logic [3:0]          uv_cnt [NCH];

    function automatic logic [3:0] bump(input logic cond, input logic [3:0] cnt);
        return cond ? (cnt == DEB ? DEB : cnt + 4'd1) : 4'd0;
    endfunction

    // Two extra sign bits keep the offset add exact before clamping.
    always_comb begin
        sum = $signed({1'b0, s1_prod}) + $signed({{2{cal_offset[W-1]}}, cal_offset});
        sat = sum[W+1] ? '0 : sum[W] ? '1 : sum[W-1:0];
        ovc = volt_out > ov_set;
        uvc = !ovc && volt_out < uv_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_prod    <= '0;
            volt_valid <= 1'b0;
            volt_ch    <= '0;
            volt_out   <= '0;
        end else begin
            s1_valid   <= data_valid && int'(data_ch) < NCH;
            s1_ch      <= data_ch;
            s1_prod    <= (W+1)'(((W+11)'(sample_data) * (W+11)'(cal_gain)) >> 10);
            volt_valid <= s1_valid;
            if (s1_valid) begin
                volt_out <= sat;
                volt_ch  <= s1_ch;
            end
        end
    end

    // Counters live in registers read the cycle after each write, so back-to-back samples never lose a count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov       <= '0;
            uv       <= '0;
            ov_latch <= 1'b0;
            uv_latch <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                ov_cnt[c] <= 4'd0;
                uv_cnt[c] <= 4'd0;
            end
        end else begin
            ov_latch <= |ov || (ov_latch && !fault_clr);
            uv_latch <= |uv || (uv_latch && !fault_clr);
            for (int c = 0; c < NCH; c++) begin
                if (volt_valid && int'(volt_ch) == c) begin
                    ov_cnt[c] <= bump(ovc, ov_cnt[c]);
                    uv_cnt[c] <= bump(uvc, uv_cnt[c]);
                    ov[c]     <= bump(ovc, ov_cnt[c]) == DEB || (ov[c] && volt_out >= ov_clr);
                    uv[c]     <= bump(uvc, uv_cnt[c]) == DEB || (uv[c] && volt_out <= uv_clr);
                end
            end
        end
    end
endmodule

// File: tb/tb_dc_volt_monitor.sv
// tb_dc_volt_monitor: randomized and directed checks of dc_volt_monitor against an arithmetic reference model.
module tb_dc_volt_monitor;
    localparam int DEB = 3, OVS = 3834, OVC = 3700, UVS = 1667, UVC = 1800;

    logic        clk = 1'b0;
    logic        rst, data_valid, dv3, fault_clr;
    logic [1:0]  data_ch;
    logic [11:0] sample_data, cal_offset;
    logic [10:0] cal_gain;
    logic [11:0] volt_out, volt_out3;
    logic [1:0]  volt_ch, volt_ch3;
    logic        volt_valid, volt_valid3;
    logic [3:0]  ov, uv;
    logic [2:0]  ov3, uv3;
    logic        ov_latch, uv_latch, ov_latch3, uv_latch3;

    int checks = 0, errors = 0;
    int oc[4], uc[4];
    logic [3:0] m_ov, m_uv;
    logic ml_ov, ml_uv;
    int g = 1024, o = 0;
    int b_ch[$], b_s[$];

    always #5 clk = ~clk;

    dc_volt_monitor #(.W(12), .NCH(4), .CHW(2), .DEB_N(DEB)) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ch(data_ch), .sample_data(sample_data),
        .cal_gain(cal_gain), .cal_offset(cal_offset), .ov_set(12'(OVS)), .ov_clr(12'(OVC)),
        .uv_set(12'(UVS)), .uv_clr(12'(UVC)), .fault_clr(fault_clr), .volt_out(volt_out),
        .volt_ch(volt_ch), .volt_valid(volt_valid), .ov(ov), .uv(uv), .ov_latch(ov_latch), .uv_latch(uv_latch)
    );

    dc_volt_monitor #(.W(12), .NCH(3), .CHW(2), .DEB_N(DEB)) dut3 (
        .clk(clk), .rst(rst), .data_valid(dv3), .data_ch(data_ch), .sample_data(sample_data),
        .cal_gain(cal_gain), .cal_offset(cal_offset), .ov_set(12'(OVS)), .ov_clr(12'(OVC)),
        .uv_set(12'(UVS)), .uv_clr(12'(UVC)), .fault_clr(fault_clr), .volt_out(volt_out3),
        .volt_ch(volt_ch3), .volt_valid(volt_valid3), .ov(ov3), .uv(uv3), .ov_latch(ov_latch3), .uv_latch(uv_latch3)
    );

    function automatic int exp_volt(int s);
        int v = (s * g) / 1024 + o;
        return v < 0 ? 0 : v > 4095 ? 4095 : v;
    endfunction

    function automatic void model_sample(int ch, int v);
        bit ovc = v > OVS;
        bit uvc = !ovc && v < UVS;
        oc[ch] = ovc ? (oc[ch] < DEB ? oc[ch] + 1 : DEB) : 0;
        uc[ch] = uvc ? (uc[ch] < DEB ? uc[ch] + 1 : DEB) : 0;
        if (oc[ch] == DEB) m_ov[ch] = 1'b1; else if (v < OVC) m_ov[ch] = 1'b0;
        if (uc[ch] == DEB) m_uv[ch] = 1'b1; else if (v > UVC) m_uv[ch] = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin oc[c] = 0; uc[c] = 0; end
        m_ov = '0; m_uv = '0; ml_ov = 1'b0; ml_uv = 1'b0;
    endfunction

    task automatic push(input int ch, input int s);
        b_ch.push_back(ch);
        b_s.push_back(s);
    endtask

    // Streams the queued samples on consecutive cycles, checking every output each cycle.
    task automatic run_burst();
        int k = b_ch.size();
        int ev;
        cal_gain = 11'(g);
        cal_offset = 12'(o);
        for (int i = 0; i <= k + 3; i++) begin
            @(posedge clk); #1;
            ml_ov = ml_ov | (|m_ov);
            ml_uv = ml_uv | (|m_uv);
            if (i >= 2 && i - 2 < k) begin
                ev = exp_volt(b_s[i-2]);
                checks++;
                if (volt_valid !== 1'b1 || volt_out !== 12'(ev) || volt_ch !== 2'(b_ch[i-2])) begin
                    errors++;
                    $display("FAIL volt[%0d]: valid=%b out=%0d ch=%0d, expected valid=1 out=%0d ch=%0d",
                             i - 2, volt_valid, volt_out, volt_ch, ev, b_ch[i-2]);
                end
            end else if (i >= 2) begin
                checks++;
                if (volt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_valid: valid=%b expected 0", volt_valid);
                end
            end
            if (i >= 3 && i - 3 < k) model_sample(b_ch[i-3], exp_volt(b_s[i-3]));
            checks++;
            if (ov !== m_ov || uv !== m_uv) begin
                errors++;
                $display("FAIL flags@%0d: ov=%b uv=%b expected ov=%b uv=%b", i, ov, uv, m_ov, m_uv);
            end
            checks++;
            if (ov_latch !== ml_ov || uv_latch !== ml_uv) begin
                errors++;
                $display("FAIL latch@%0d: ov_latch=%b uv_latch=%b expected %b %b", i, ov_latch, uv_latch, ml_ov, ml_uv);
            end
            if (i < k) begin
                data_valid = 1'b1; data_ch = 2'(b_ch[i]); sample_data = 12'(b_s[i]);
            end else data_valid = 1'b0;
        end
        b_ch.delete();
        b_s.delete();
    endtask

    task automatic test_fault_clr();
        @(posedge clk); #1;
        ml_ov = ml_ov | (|m_ov);
        ml_uv = ml_uv | (|m_uv);
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        ml_ov = |m_ov;
        ml_uv = |m_uv;
        checks++;
        if (ov_latch !== ml_ov || uv_latch !== ml_uv) begin
            errors++;
            $display("FAIL fault_clr: ov_latch=%b uv_latch=%b expected %b %b", ov_latch, uv_latch, ml_ov, ml_uv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b0; dv3 = 1'b0; fault_clr = 1'b0;
        data_ch = '0; sample_data = '0; cal_gain = 11'd1024; cal_offset = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({volt_out, volt_ch, volt_valid, ov, uv, ov_latch, uv_latch} !== '0) begin
            errors++;
            $display("FAIL reset: out=%0d ch=%0d valid=%b ov=%b uv=%b latches=%b%b expected all 0",
                     volt_out, volt_ch, volt_valid, ov, uv, ov_latch, uv_latch);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_calibration();
        g = 1024; o = 0; push(2, 2000); run_burst();
        g = 970; push(2, 4095); run_burst();
        g = 1024; o = 20; push(2, 4090); run_burst();
        o = -20; push(2, 10); run_burst();
        o = 0;
    endtask

    task automatic test_ov_debounce();
        push(1, 3900); push(1, 3900); push(1, 3800); push(1, 3900); push(1, 3900); push(1, 3900);
        run_burst();
        checks++;
        if (ov !== 4'b0010 || ov_latch !== 1'b1) begin
            errors++;
            $display("FAIL ov_debounce: ov=%b ov_latch=%b expected ov=0010 ov_latch=1", ov, ov_latch);
        end
    endtask

    task automatic test_ov_clear();
        push(1, 3800); run_burst();
        checks++;
        if (ov[1] !== 1'b1) begin errors++; $display("FAIL ov_hold: ov[1]=%b expected 1", ov[1]); end
        push(1, 3699); run_burst();
        checks++;
        if (ov[1] !== 1'b0 || ov_latch !== 1'b1) begin
            errors++;
            $display("FAIL ov_clear: ov[1]=%b ov_latch=%b expected 0 1", ov[1], ov_latch);
        end
        test_fault_clr();
        push(3, 4000); push(3, 4000); push(3, 4000); run_burst();
        test_fault_clr();
        checks++;
        if (ov[3] !== 1'b1 || ov_latch !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ov[3]=%b ov_latch=%b expected 1 1", ov[3], ov_latch);
        end
        push(3, 3000); run_burst();
        test_fault_clr();
    endtask

    task automatic test_uv();
        push(3, 1600); push(3, 1600); push(3, 1600); run_burst();
        checks++;
        if (uv[3] !== 1'b1) begin errors++; $display("FAIL uv_set: uv[3]=%b expected 1", uv[3]); end
        push(3, 1750); run_burst();
        checks++;
        if (uv[3] !== 1'b1) begin errors++; $display("FAIL uv_hold: uv[3]=%b expected 1", uv[3]); end
        push(3, 1801); run_burst();
        checks++;
        if (uv[3] !== 1'b0) begin errors++; $display("FAIL uv_clear: uv[3]=%b expected 0", uv[3]); end
    endtask

    task automatic test_back_to_back();
        push(0, 4000); push(0, 4000); push(0, 4000); run_burst();
        checks++;
        if (ov[0] !== 1'b1) begin errors++; $display("FAIL back_to_back: ov[0]=%b expected 1", ov[0]); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        data_valid = 1'b1; data_ch = 2'd0; sample_data = 12'd4000;
        @(posedge clk); #1;
        data_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({volt_out, volt_ch, volt_valid, ov, uv, ov_latch, uv_latch} !== '0) begin
            errors++;
            $display("FAIL reset_mid: out=%0d valid=%b ov=%b uv=%b latches=%b%b expected all 0",
                     volt_out, volt_valid, ov, uv, ov_latch, uv_latch);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (volt_valid !== 1'b0 || ov !== 4'b0 || ov_latch !== 1'b0) begin
                errors++;
                $display("FAIL post_reset[%0d]: valid=%b ov=%b ov_latch=%b expected 0", i, volt_valid, ov, ov_latch);
            end
        end
    endtask

    task automatic test_random();
        int k, sel;
        for (int n = 0; n < 12; n++) begin
            g = $urandom_range(900, 1100);
            o = int'($urandom_range(0, 128)) - 64;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                sel = $urandom_range(0, 2);
                push($urandom_range(0, 3), sel == 0 ? $urandom_range(0, 4095) :
                                           sel == 1 ? $urandom_range(3650, 4000) : $urandom_range(1500, 1900));
            end
            run_burst();
            if ($urandom_range(0, 3) == 0) test_fault_clr();
        end
        g = 1024; o = 0;
        cal_gain = 11'd1024; cal_offset = '0;
    endtask

    task automatic test_discard();
        @(posedge clk); #1;
        dv3 = 1'b1; data_ch = 2'd3; sample_data = 12'd1000;
        @(posedge clk); #1;
        dv3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (volt_valid3 !== 1'b0 || ov3 !== 3'b0 || uv3 !== 3'b0 || ov_latch3 !== 1'b0) begin
                errors++;
                $display("FAIL discard[%0d]: valid=%b ov=%b uv=%b latch=%b expected 0", i, volt_valid3, ov3, uv3, ov_latch3);
            end
        end
        dv3 = 1'b1; data_ch = 2'd2; sample_data = 12'd2000;
        @(posedge clk); #1;
        dv3 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (volt_valid3 !== 1'b1 || volt_out3 !== 12'd2000 || volt_ch3 !== 2'd2) begin
            errors++;
            $display("FAIL nch3_accept: valid=%b out=%0d ch=%0d expected 1 2000 2", volt_valid3, volt_out3, volt_ch3);
        end
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_ov_debounce();
        test_ov_clear();
        test_uv();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_discard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
